// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_unit_if #(
  parameter int unsigned ALUOP_W = 2
);
  logic [6:0]         opcode;
  logic               mem_ready;
  logic               pcWrite;
  logic               branch;
  logic               pcSrc;
  logic               irWrite;
  logic               iord;
  logic               memRead;
  logic               memWrite;
  logic               regWrite;
  logic [1:0]         memToReg;
  logic [1:0]         aluSrcA;
  logic [1:0]         aluSrcB;
  logic [ALUOP_W-1:0] aluOp;
  logic               illegal;
  logic               timeout;
  logic [2:0]         state_o;

  modport master (
    input  opcode, mem_ready,
    output pcWrite, branch, pcSrc, irWrite, iord, memRead, memWrite, regWrite,
           memToReg, aluSrcA, aluSrcB, aluOp, illegal, timeout, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pcWrite, branch, pcSrc, irWrite, iord, memRead, memWrite, regWrite,
           memToReg, aluSrcA, aluSrcB, aluOp, illegal, timeout, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout and
// illegal-opcode trap. Define CTRL_JUMP_EN to add JAL and LUI support.
module multicycle_control_unit #(
  parameter int unsigned ALUOP_W      = 2,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                         clk,
  input logic                         rst,
  multicycle_control_unit_if.master   ctrl
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  state_t           state;
  logic [6:0]       opQ;
  logic [CNT_W-1:0] waitCnt;
  logic             illegalQ;
  logic             timeoutQ;
  logic [1:0]       aluOpRaw;

  function automatic logic supported(input logic [6:0] op);
    logic ok;
    ok = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
         (op == OP_STORE) || (op == OP_BRANCH);
`ifdef CTRL_JUMP_EN
    ok = ok || (op == OP_JAL) || (op == OP_LUI);
`else
    ok = ok;
`endif
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      opQ      <= '0;
      waitCnt  <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      case (state)
        FETCH, MEM: begin
          // mem_ready takes priority over an expiring wait count in the same cycle
          if (ctrl.mem_ready) begin
            waitCnt <= '0;
            if (state == FETCH)
              state <= DECODE;
            else
              state <= (opQ == OP_LOAD) ? WB : FETCH;
          end else if ((MEM_WAIT_MAX != 0) && (waitCnt == CNT_W'(MEM_WAIT_MAX))) begin
            waitCnt  <= '0;
            state    <= TRAP;
            timeoutQ <= 1'b1;
          end else if (waitCnt != '1) begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        DECODE: begin
          waitCnt <= '0;
          opQ     <= ctrl.opcode;
          if (supported(ctrl.opcode)) begin
            state <= EXEC;
          end else begin
            state    <= TRAP;
            illegalQ <= 1'b1;
          end
        end
        EXEC: begin
          waitCnt <= '0;
          case (opQ)
            OP_R, OP_I:         state <= WB;
            OP_LOAD, OP_STORE:  state <= MEM;
`ifdef CTRL_JUMP_EN
            OP_JAL, OP_LUI:     state <= WB;
`endif
            default:            state <= FETCH;
          endcase
        end
        WB: begin
          waitCnt <= '0;
          state   <= FETCH;
        end
        TRAP: begin
          waitCnt <= '0;
          state   <= TRAP;
        end
        default: begin
          waitCnt <= '0;
          state   <= FETCH;
        end
      endcase
    end
  end

  // Moore decode from state/opQ; only irWrite/pcWrite in FETCH follow mem_ready directly
  always_comb begin
    ctrl.pcWrite  = 1'b0;
    ctrl.branch   = 1'b0;
    ctrl.pcSrc    = 1'b0;
    ctrl.irWrite  = 1'b0;
    ctrl.iord     = 1'b0;
    ctrl.memRead  = 1'b0;
    ctrl.memWrite = 1'b0;
    ctrl.regWrite = 1'b0;
    ctrl.memToReg = 2'b00;
    ctrl.aluSrcA  = 2'b00;
    ctrl.aluSrcB  = 2'b00;
    aluOpRaw      = 2'b00;
    if (!rst) begin
      case (state)
        FETCH: begin
          ctrl.memRead = 1'b1;
          ctrl.aluSrcB = 2'b01;
          ctrl.irWrite = ctrl.mem_ready;
          ctrl.pcWrite = ctrl.mem_ready;
        end
        DECODE: begin
          ctrl.aluSrcA = 2'b10;
          ctrl.aluSrcB = 2'b10;
        end
        EXEC: begin
          case (opQ)
            OP_R: begin
              ctrl.aluSrcA = 2'b01;
              aluOpRaw     = 2'b10;
            end
            OP_I: begin
              ctrl.aluSrcA = 2'b01;
              ctrl.aluSrcB = 2'b10;
              aluOpRaw     = 2'b11;
            end
            OP_LOAD, OP_STORE: begin
              ctrl.aluSrcA = 2'b01;
              ctrl.aluSrcB = 2'b10;
            end
            OP_BRANCH: begin
              ctrl.aluSrcA = 2'b01;
              aluOpRaw     = 2'b01;
              ctrl.branch  = 1'b1;
              ctrl.pcSrc   = 1'b1;
            end
`ifdef CTRL_JUMP_EN
            OP_JAL: begin
              ctrl.pcWrite = 1'b1;
              ctrl.pcSrc   = 1'b1;
            end
            OP_LUI: begin
              ctrl.aluSrcA = 2'b11;
              ctrl.aluSrcB = 2'b10;
            end
`endif
            default: ;
          endcase
        end
        MEM: begin
          ctrl.iord = 1'b1;
          if (opQ == OP_LOAD)
            ctrl.memRead = 1'b1;
          else
            ctrl.memWrite = 1'b1;
        end
        WB: begin
          ctrl.regWrite = 1'b1;
          if (opQ == OP_LOAD)
            ctrl.memToReg = 2'b01;
          else if (opQ == OP_JAL)
            ctrl.memToReg = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign ctrl.aluOp   = ALUOP_W'(aluOpRaw);
  assign ctrl.illegal = illegalQ;
  assign ctrl.timeout = timeoutQ;
  assign ctrl.state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (MEM_WAIT_MAX=4).
// Each observation packs {illegal, timeout, state, 8 enables, memToReg, aluSrcA, aluSrcB, aluOp}.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALUOP_W(2)) bus ();

  multicycle_control_unit #(
    .ALUOP_W      (2),
    .MEM_WAIT_MAX (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int checks = 0;
  int errors = 0;

  // enables order: pcWrite branch pcSrc irWrite iord memRead memWrite regWrite
  localparam logic [20:0] ALL0     = 21'b0;
  localparam logic [20:0] F_RDY    = {2'b00, 3'd0, 8'b10010100, 2'b00, 2'b00, 2'b01, 2'b00};
  localparam logic [20:0] F_WAIT   = {2'b00, 3'd0, 8'b00000100, 2'b00, 2'b00, 2'b01, 2'b00};
  localparam logic [20:0] DEC      = {2'b00, 3'd1, 8'b00000000, 2'b00, 2'b10, 2'b10, 2'b00};
  localparam logic [20:0] EX_R     = {2'b00, 3'd2, 8'b00000000, 2'b00, 2'b01, 2'b00, 2'b10};
  localparam logic [20:0] EX_LS    = {2'b00, 3'd2, 8'b00000000, 2'b00, 2'b01, 2'b10, 2'b00};
  localparam logic [20:0] EX_BR    = {2'b00, 3'd2, 8'b01100000, 2'b00, 2'b01, 2'b00, 2'b01};
  localparam logic [20:0] EX_JAL   = {2'b00, 3'd2, 8'b10100000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] MEM_LD   = {2'b00, 3'd3, 8'b00001100, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] MEM_ST   = {2'b00, 3'd3, 8'b00001010, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] MEM_RST  = {2'b00, 3'd3, 8'b00000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] WB_ALU   = {2'b00, 3'd4, 8'b00000001, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] WB_LD    = {2'b00, 3'd4, 8'b00000001, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] WB_JAL   = {2'b00, 3'd4, 8'b00000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] TRAP_ILL = {2'b10, 3'd7, 8'b00000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [20:0] TRAP_TO  = {2'b01, 3'd7, 8'b00000000, 2'b00, 2'b00, 2'b00, 2'b00};

  function automatic logic [20:0] obs();
    return {bus.illegal, bus.timeout, bus.state_o,
            bus.pcWrite, bus.branch, bus.pcSrc, bus.irWrite,
            bus.iord, bus.memRead, bus.memWrite, bus.regWrite,
            bus.memToReg, bus.aluSrcA, bus.aluSrcB, bus.aluOp};
  endfunction

  // Reset is applied at the next rising edge; the following step releases it.
  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 7'b0110011;
    #1 got = obs();
    checks++;
    if (got !== ALL0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", got, ALL0);
    end
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    #1 got = obs();
    checks++;
    if (got !== F_WAIT) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", got, F_WAIT);
    end
  endtask

  task automatic test_rtype();
    logic [20:0] ex[$];
    bit          rd[$];
    logic [20:0] got;
    doReset();
    bus.opcode = 7'b0110011;
    ex = '{F_RDY, DEC, EX_R, WB_ALU, F_WAIT};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rd[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL rtype[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [20:0] ex[$];
    bit          rd[$];
    logic [20:0] got;
    doReset();
    bus.opcode = 7'b0000011;
    ex = '{F_RDY, DEC, EX_LS, MEM_LD, MEM_LD, MEM_LD, MEM_LD, WB_LD, F_WAIT};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rd[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL load_wait[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_store_reset();
    logic [20:0] ex[$];
    bit          rd[$];
    bit          rs[$];
    logic [20:0] got;
    doReset();
    bus.opcode = 7'b0100011;
    ex = '{F_RDY, DEC, EX_LS, MEM_ST, MEM_RST, F_WAIT};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = rs[i];
      bus.mem_ready = rd[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL store_reset[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_store_branch_back_to_back();
    logic [20:0] ex[$];
    bit          rd[$];
    logic [6:0]  op[$];
    logic [20:0] got;
    doReset();
    ex = '{F_RDY, DEC, EX_LS, MEM_ST, F_RDY, DEC, EX_BR, F_WAIT};
    rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    op = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011,
           7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rd[i];
      bus.opcode = op[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL store_branch[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [20:0] ex[$];
    bit          rd[$];
    logic [20:0] got;
    doReset();
    bus.opcode = 7'b0110011;
    ex = '{F_WAIT, F_WAIT, F_WAIT, F_WAIT, F_WAIT, TRAP_TO, TRAP_TO, TRAP_TO, TRAP_TO};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rd[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL timeout[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
    doReset();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1 got = obs();
    checks++;
    if (got !== F_WAIT) begin
      errors++;
      $display("FAIL timeout_cleared: got %b expected %b", got, F_WAIT);
    end
  endtask

  task automatic test_timeout_boundary();
    logic [20:0] ex[$];
    bit          rd[$];
    logic [20:0] got;
    doReset();
    bus.opcode = 7'b0110011;
    ex = '{F_WAIT, F_WAIT, F_WAIT, F_WAIT, F_RDY, DEC, EX_R, WB_ALU, F_WAIT};
    rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rd[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL timeout_boundary[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [20:0] got;
    logic [20:0] ex[$];
    doReset();
    bus.opcode = 7'b1111111;
    ex = '{F_RDY, DEC};
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = (i == 0) ? 1'b1 : 1'(i % 2);
      #1 got = obs();
      checks++;
      if (got !== ((i < 2) ? ex[i] : TRAP_ILL)) begin
        errors++;
        $display("FAIL illegal[%0d]: got %b expected %b", i, got,
                 (i < 2) ? ex[i] : TRAP_ILL);
      end
    end
  endtask

  task automatic test_jal();
    logic [20:0] ex[$];
    bit          rd[$];
    logic [20:0] got;
    doReset();
    bus.opcode = 7'b1101111;
`ifdef CTRL_JUMP_EN
    ex = '{F_RDY, DEC, EX_JAL, WB_JAL, F_WAIT};
`else
    ex = '{F_RDY, DEC, TRAP_ILL, TRAP_ILL, TRAP_ILL};
`endif
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ready = rd[i];
      #1 got = obs();
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL jal[%0d]: got %b expected %b", i, got, ex[i]);
      end
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode    = 7'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_reset();
    test_store_branch_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_illegal();
    test_jal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
